// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame edge
// positions, idle line level and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    WAIT_IDLE
  } ps2State_e;

  // Device falling-edge numbers within a host-to-device frame
  localparam int unsigned PS2_FRAME_EDGES = 11;
  localparam int unsigned PS2_ACK_EDGE    = 11;
  localparam int unsigned PS2_STOP_EDGE   = 10;
  localparam int unsigned PS2_PARITY_EDGE = 9;

  localparam int unsigned EDGE_W = 4;

  // Released open-collector lines float high through the pull-ups
  localparam logic PS2_IDLE_LEVEL = 1'b1;

  // PS/2 uses odd parity over the eight data bits
  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchroniser and falling-edge detector for one PS/2 pad input.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   padIn     - raw asynchronous pad level
//   level     - synchronised level (SYNC_STAGES flops deep)
//   fall      - registered single-cycle strobe on a 1->0 of level
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic padIn,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  assign level = chain[SYNC_STAGES-1];

  // Flops start at the idle level so reset never manufactures an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      prev  <= PS2_IDLE_LEVEL;
      fall  <= 1'b0;
    end else begin
      chain <= SYNC_STAGES'({chain, padIn});
      prev  <= chain[SYNC_STAGES-1];
      fall  <= prev & ~chain[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send,
// shifts one command byte out on device clock edges and checks the ACK.
// Ports:
//   clk, rst                 - system clock, synchronous active-high reset
//   tx_data, tx_valid        - command byte and send request
//   tx_ready                 - high only while idle (accept = valid && ready)
//   ps2_clk_i, ps2_data_i    - pad inputs
//   ps2_clk_oe, ps2_data_oe  - 1 pulls the matching line low
//   busy                     - high whenever not idle
//   tx_done, tx_error        - one-cycle completion / failure pulses
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2State_e          state;
  logic [7:0]         shreg;
  logic               parity;
  logic [EDGE_W-1:0]  edgeCnt;
  logic [INH_W-1:0]   inhCnt;
  logic [TO_W-1:0]    toCnt;
  logic               clkSync;
  logic               clkFall;
  logic               dataSync;
  logic               unusedDataFall;
  logic               toHit;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uClkSync (
    .clk   (clk),
    .rst   (rst),
    .padIn (ps2_clk_i),
    .level (clkSync),
    .fall  (clkFall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) uDataSync (
    .clk   (clk),
    .rst   (rst),
    .padIn (ps2_data_i),
    .level (dataSync),
    .fall  (unusedDataFall)
  );

  assign toHit = (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Transmit sequencer; every transition back to IDLE releases both lines
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      parity      <= 1'b0;
      edgeCnt     <= '0;
      inhCnt      <= '0;
      toCnt       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          // Accepting aborts any frame the device may have started
          if (tx_valid && tx_ready) begin
            shreg       <= tx_data;
            parity      <= oddParity(tx_data);
            edgeCnt     <= '0;
            toCnt       <= '0;
            inhCnt      <= INH_W'(INHIBIT_CYCLES - 1);
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= (INHIBIT_CYCLES == 1);
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Down-count; start bit goes out during the final held-low cycle
          if (inhCnt == '0) begin
            ps2_clk_oe <= 1'b0;
            state      <= REQ;
          end else begin
            inhCnt <= inhCnt - 1'b1;
            if (inhCnt == INH_W'(1)) ps2_data_oe <= 1'b1;
          end
        end
        REQ, XFER: begin
          if (clkFall) begin
            toCnt   <= '0;
            edgeCnt <= edgeCnt + 1'b1;
            state   <= XFER;
            // edgeCnt still holds the previous edge number here
            if (edgeCnt < EDGE_W'(PS2_PARITY_EDGE - 1)) begin
              ps2_data_oe <= ~shreg[edgeCnt[2:0]];
            end else if (edgeCnt == EDGE_W'(PS2_PARITY_EDGE - 1)) begin
              ps2_data_oe <= ~parity;
            end else if (edgeCnt == EDGE_W'(PS2_STOP_EDGE - 1)) begin
              ps2_data_oe <= 1'b0;
            end else begin
              ps2_data_oe <= 1'b0;
              if (!dataSync) begin
                state <= WAIT_IDLE;
              end else begin
                tx_error <= 1'b1;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end
            end
          end else if (toHit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clkSync && dataSync) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (toHit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector bus plus a PS/2 device model
// that clocks at 40-cycle half periods, samples on rising edges and ACKs.
// Expected frames are queued on send and compared when the device has
// captured a frame.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TO   = 500;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txData = '0;
  logic       txValid = 1'b0;
  logic       txReady, ps2ClkOe, ps2DataOe, busy, txDone, txError;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  logic       ps2Clk, ps2Data;

  int  nVec = 0;
  int  nMis = 0;
  int  doneCnt = 0;
  int  errCnt = 0;
  int  inhRun = 0;
  int  lastInhRun = 0;
  bit  bothSeen = 1'b0;
  logic [10:0] expQ[$];

  assign ps2Clk  = devClk & ~ps2ClkOe;
  assign ps2Data = devData & ~ps2DataOe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (txData),
    .tx_valid    (txValid),
    .tx_ready    (txReady),
    .ps2_clk_i   (ps2Clk),
    .ps2_data_i  (ps2Data),
    .ps2_clk_oe  (ps2ClkOe),
    .ps2_data_oe (ps2DataOe),
    .busy        (busy),
    .tx_done     (txDone),
    .tx_error    (txError)
  );

  // Pulse counters and inhibit run-length, sampled mid-cycle
  always @(negedge clk) begin
    if (txDone) doneCnt++;
    if (txError) errCnt++;
    if (txDone && txError) bothSeen = 1'b1;
    if (ps2ClkOe) inhRun++;
    else if (inhRun != 0) begin
      lastInhRun = inhRun;
      inhRun = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // bit0 start, bits1..8 data LSB first, bit9 odd parity, bit10 stop
  function automatic logic [10:0] frameOf(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic popExp(output logic [10:0] exp);
    checkVal("sbNonEmpty", 32'(expQ.size() != 0), 1);
    exp = (expQ.size() != 0) ? expQ.pop_front() : '0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    expQ.push_back(frameOf(b));
    @(negedge clk);
    txData  = b;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    checkVal("acceptBusy", {30'd0, txReady, busy}, 32'b01);
  endtask

  // Device side: wait for request-to-send, then clock nFalls edges
  task automatic devFrame(input bit doAck, input int nFalls, output logic [10:0] got, output bit ok);
    int t = 0;
    got = '1;
    ok  = 1'b1;
    while (!(ps2ClkOe == 1'b0 && ps2DataOe == 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      ok = 1'b0;
      return;
    end
    repeat (HALF) @(negedge clk);
    got[0] = ps2Data;
    for (int i = 1; i <= nFalls; i++) begin
      devClk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == nFalls && nFalls < 11) return;
      if (i <= 10) got[i] = ps2Data;
      devClk = 1'b1;
      if (i == 10 && doAck) devData = 1'b0;
      if (i == 11) devData = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic runFrame(input logic [7:0] b, input bit doAck, input logic expPar, input string tag);
    int d0 = doneCnt;
    int e0 = errCnt;
    logic [10:0] got, exp;
    bit ok;
    lastInhRun = 0;
    sendByte(b);
    devFrame(doAck, 11, got, ok);
    checkVal({tag, "-reqSeen"}, 32'(ok), 1);
    popExp(exp);
    checkVal({tag, "-frame"}, 32'(got), 32'(exp));
    checkVal({tag, "-parity"}, 32'(got[9]), 32'(expPar));
    checkVal({tag, "-inhibit"}, 32'(lastInhRun), INH);
    repeat (10) @(negedge clk);
    checkVal({tag, "-done"}, 32'(doneCnt - d0), doAck ? 1 : 0);
    checkVal({tag, "-error"}, 32'(errCnt - e0), doAck ? 0 : 1);
    checkVal({tag, "-idle"}, {29'd0, txReady, ps2ClkOe, ps2DataOe}, 32'b100);
  endtask

  initial begin
    logic [10:0] got, exp;
    bit ok;
    int n, t, d0, e0;

    repeat (3) @(negedge clk);
    checkVal("resetOuts", {26'd0, txReady, ps2ClkOe, ps2DataOe, busy, txDone, txError}, 32'b100000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    runFrame(8'hED, 1'b1, 1'b1, "ed");
    runFrame(8'h01, 1'b1, 1'b0, "x01");
    runFrame(8'h00, 1'b1, 1'b1, "x00");
    runFrame(8'hFF, 1'b1, 1'b1, "xff");

    // Device never clocks: timeout counted from clock release
    e0 = errCnt;
    sendByte(8'hA5);
    t = 0;
    while (ps2ClkOe && t < 100) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (!txError && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkVal("toCycles", 32'(n), TO);
    checkVal("toLines", {30'd0, ps2ClkOe, ps2DataOe}, 0);
    checkVal("toIdle", {30'd0, txReady, busy}, 32'b10);
    popExp(exp);
    repeat (5) @(negedge clk);
    checkVal("toErrCnt", 32'(errCnt - e0), 1);

    runFrame(8'h5A, 1'b0, 1'b1, "nack");

    // Reset after the 5th falling edge (bit4 of 0x2C is 0, so data is held low)
    d0 = doneCnt;
    e0 = errCnt;
    sendByte(8'h2C);
    devFrame(1'b1, 5, got, ok);
    checkVal("rstReqSeen", 32'(ok), 1);
    checkVal("rstPreDataOe", 32'(ps2DataOe), 1);
    rst = 1'b1;
    @(negedge clk);
    checkVal("rstRelease", {27'd0, ps2ClkOe, ps2DataOe, busy, txDone, txError}, 0);
    rst = 1'b0;
    devClk = 1'b1;
    devData = 1'b1;
    popExp(exp);
    repeat (20) @(negedge clk);
    checkVal("rstNoPulse", 32'(doneCnt - d0 + errCnt - e0), 0);

    runFrame(8'hF4, 1'b1, 1'b0, "f4");

    // A second request while busy must be dropped
    fork
      runFrame(8'h12, 1'b1, 1'b1, "ign");
      begin
        repeat (200) @(negedge clk);
        txData  = 8'h34;
        txValid = 1'b1;
        repeat (100) @(negedge clk);
        checkVal("ignBusyReady", 32'(txReady), 0);
        txValid = 1'b0;
      end
    join
    lastInhRun = 0;
    repeat (300) @(negedge clk);
    checkVal("ignNoSecond", 32'(lastInhRun + inhRun), 0);

    checkVal("sbDrained", 32'(expQ.size()), 0);
    checkVal("doneErrExcl", 32'(bothSeen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
